addr_dec_resp_mux_outstanding: RTL and testbench
================================================

Name: addr_dec_resp_mux_outstanding

Overview:
Per-master address decoder and response mux for the variable-latency TCDM crossbar, with up to MaxOutstanding in-flight transactions. The existing single-inflight decoder allows only one. This block tracks an outstanding counter and the target bank. It keeps responses in order by blocking bank switches until the current bank has drained. It sits between one master port and the NumOut slave-side request/response lanes of the full crossbar.

Parameters:
NumOut, 32, number of slave lanes (banks); must be >= 1
ReqDataWidth, 32, request payload width
RespDataWidth, 32, response payload width
MaxOutstanding, 4, max in-flight transactions per master; must be >= 1
AggregateGnt, 1, 1: gnt_o uses OR of all gnt_i; 0: gnt_o uses gnt_i[add_i]
LogNumOut, (NumOut>1 ? $clog2(NumOut) : 1), bank index width
CntWidth, $clog2(MaxOutstanding+1), counter width

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  master request
add_i  in  LogNumOut  target bank index
data_i  in  ReqDataWidth  request payload
gnt_o  out  1  grant to master (issue accepted)
vld_o  out  1  response valid to master
rdata_o  out  RespDataWidth  response payload
req_o  out  NumOut  decoded one-hot request to slaves
gnt_i  in  NumOut  slave grants
vld_i  in  NumOut  slave response valids
data_o  out  NumOut x ReqDataWidth  payload broadcast to all lanes
rdata_i  in  NumOut x RespDataWidth  slave responses
outstanding_o  out  CntWidth  current in-flight count (cnt_q)
stray_vld_o  out  1  one-cycle pulse: vld_i[bank_q] seen while cnt_q==0

Behaviour:
- Reset is asynchronous, active-low. It sets cnt_q=0 and bank_q=0. Any reset mid-operation discards all in-flight tracking; late slave responses after reset are reported as stray and are not forwarded.
- resp_fire = vld_i[bank_q] & (cnt_q!=0). vld_o = resp_fire. rdata_o = rdata_i[bank_q], mux driven by the registered bank_q only.
- stray_vld_o = vld_i[bank_q] & (cnt_q==0). It is combinational and is never forwarded. vld_i on lanes other than bank_q is ignored.
- same_bank = (cnt_q==0) | (add_i==bank_q) | (cnt_q==1 & resp_fire). The last term gives a zero-bubble bank switch on the draining response.
- room = (cnt_q < MaxOutstanding) | resp_fire. At full, an issue is allowed only in a cycle that retires one.
- issue_ok = req_i & same_bank & room. req_o[add_i] = issue_ok; all other lanes are 0. When issue_ok=0, req_o = 0 (gated).
- gnt_o = issue_ok & (AggregateGnt ? |gnt_i : gnt_i[add_i]). issue_fire = gnt_o.
- cnt_d = cnt_q + issue_fire - resp_fire. Issue and response in the same cycle leave the count unchanged. The count never exceeds MaxOutstanding and never underflows (resp_fire requires cnt_q!=0).
- bank_q <= add_i on issue_fire; otherwise it holds.
- Latency: the request decode is combinational, 0 cycles. A response is forwarded combinationally in the cycle vld_i is seen, with no added latency.
- data_o = data_i replicated on every lane.
- Ordering rule: every slave returns responses in order per requester. All in-flight transactions target bank_q, so responses reach the master in issue order.
- NumOut==1: add_i is ignored, lane 0 is always used, same_bank is always 1, and bank_q stays 0.
- MaxOutstanding==1 reproduces single-inflight behaviour, plus back-to-back issue on the response cycle.

Decomposition:
- No shared package is needed. The only constant is CntWidth, derived locally; no typedefs are exported.
- One natural sub-module: outstanding_tracker. It holds cnt_q and bank_q and exposes resp_fire, same_bank, room and stray. It takes issue_fire, add_i and vld_i[bank_q] as inputs.
- The decode and mux logic stay in the top level.

Test Plan:
1. Reset with req_i=1, add_i=3: during reset, outstanding_o=0 and vld_o=0. After release with gnt_i[3]=1: req_o=0x8 and gnt_o=1, and next cycle outstanding_o=1.
2. MaxOutstanding=4, bank 5 always granted, no vld_i: four grants are accepted and outstanding_o=4. On the fifth cycle req_o=0 and gnt_o=0. Then vld_i[5]=1 with req_i=1: vld_o=1, gnt_o=1, and outstanding_o stays 4.
3. Two issues to bank 2 in flight, then req_i to bank 7: req_o=0 until the second vld_i[2]. In that cycle req_o=0x80, gnt_o=1 and vld_o=1 with rdata_o=rdata_i[2]. Next cycle bank_q=7 and outstanding_o=1.
4. Stray response: vld_i[0]=1 at outstanding_o=0 gives vld_o=0 and stray_vld_o=1 for one cycle. vld_i[4]=1 while bank_q=1 gives no vld_o and no change to outstanding_o.
5. AggregateGnt=0: req_i to bank 1 with gnt_i=0x4 gives gnt_o=0 and no count increment. With gnt_i=0x2, gnt_o=1.
6. Assert rst_ni low with outstanding_o=3: outstanding_o=0 immediately. A later vld_i on the old bank pulses stray_vld_o, and vld_o stays 0.

Source files
------------

// File: rtl/addr_dec_resp_mux_outstanding_tracker.sv
// In-flight tracker: outstanding count and locked bank for one master.
// Drives the ordering and room qualifiers used by the request decoder.
module addr_dec_resp_mux_outstanding_tracker #(
    parameter int unsigned NumOut         = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned LogNumOut      = (NumOut > 1) ? $clog2(NumOut) : 1,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 issue_fire,
    input  logic [LogNumOut-1:0] add,
    input  logic                 vld_bank,
    output logic [CntWidth-1:0]  cnt_q,
    output logic [LogNumOut-1:0] bank_q,
    output logic                 resp_fire,
    output logic                 same_bank,
    output logic                 room,
    output logic                 stray
);

    logic                cnt_zero;
    logic [CntWidth-1:0] cnt_d;

    assign cnt_zero  = (cnt_q == '0);
    assign resp_fire = vld_bank & ~cnt_zero;
    assign stray     = vld_bank & cnt_zero;
    assign room      = (cnt_q < CntWidth'(MaxOutstanding)) | resp_fire;
    assign cnt_d     = cnt_q + CntWidth'(issue_fire) - CntWidth'(resp_fire);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (NumOut == 1) begin : g_single
            assign bank_q    = '0;
            assign same_bank = 1'b1;
        end else begin : g_multi
            // Draining the last response frees the bank in the same cycle.
            assign same_bank = cnt_zero | (add == bank_q)
                             | ((cnt_q == CntWidth'(1)) & resp_fire);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    bank_q <= '0;
                end else if (issue_fire) begin
                    bank_q <= add;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/addr_dec_resp_mux_outstanding.sv
// Per-master address decoder and in-order response mux with
// multiple outstanding transactions confined to a single bank.
module addr_dec_resp_mux_outstanding #(
    parameter int unsigned NumOut         = 32,
    parameter int unsigned ReqDataWidth   = 32,
    parameter int unsigned RespDataWidth  = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter bit          AggregateGnt   = 1'b1,
    parameter int unsigned LogNumOut      = (NumOut > 1) ? $clog2(NumOut) : 1,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_i,
    input  logic [LogNumOut-1:0]                  add_i,
    input  logic [ReqDataWidth-1:0]               data_i,
    output logic                                  gnt_o,
    output logic                                  vld_o,
    output logic [RespDataWidth-1:0]              rdata_o,
    output logic [NumOut-1:0]                     req_o,
    input  logic [NumOut-1:0]                     gnt_i,
    input  logic [NumOut-1:0]                     vld_i,
    output logic [NumOut-1:0][ReqDataWidth-1:0]   data_o,
    input  logic [NumOut-1:0][RespDataWidth-1:0]  rdata_i,
    output logic [CntWidth-1:0]                   outstanding_o,
    output logic                                  stray_vld_o
);

    logic [LogNumOut-1:0] lane;
    logic [LogNumOut-1:0] bank_q;
    logic                 resp_fire;
    logic                 same_bank;
    logic                 room;
    logic                 issue_ok;
    logic                 gnt_sel;

    generate
        if (NumOut == 1) begin : g_lane_single
            assign lane = '0;
        end else begin : g_lane_multi
            assign lane = add_i;
        end
    endgenerate

    addr_dec_resp_mux_outstanding_tracker #(
        .NumOut         (NumOut),
        .MaxOutstanding (MaxOutstanding),
        .LogNumOut      (LogNumOut),
        .CntWidth       (CntWidth)
    ) i_tracker (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .issue_fire (gnt_o),
        .add        (lane),
        .vld_bank   (vld_i[bank_q]),
        .cnt_q      (outstanding_o),
        .bank_q     (bank_q),
        .resp_fire  (resp_fire),
        .same_bank  (same_bank),
        .room       (room),
        .stray      (stray_vld_o)
    );

    assign issue_ok = req_i & same_bank & room;
    assign gnt_sel  = AggregateGnt ? (|gnt_i) : gnt_i[lane];
    assign gnt_o    = issue_ok & gnt_sel;

    always_comb begin
        req_o       = '0;
        req_o[lane] = issue_ok;
    end

    assign vld_o   = resp_fire;
    assign rdata_o = rdata_i[bank_q];

    for (genvar i = 0; i < NumOut; i++) begin : g_data
        assign data_o[i] = data_i;
    end

endmodule

// File: tb/tb_addr_dec_resp_mux_outstanding.sv
// Directed table-driven bench for the outstanding-tracking decoder/mux.
// A second instance exercises per-lane grant selection.
module tb_addr_dec_resp_mux_outstanding;

    localparam int N  = 32;
    localparam int LW = 5;
    localparam int CW = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 req;
    logic [LW-1:0]        add;
    logic [31:0]          data;
    logic [N-1:0]         gnt;
    logic [N-1:0]         vld;
    logic [N-1:0][31:0]   rdata;

    logic                 gnt_a, vld_a, stray_a;
    logic [31:0]          rdata_a;
    logic [N-1:0]         req_a;
    logic [N-1:0][31:0]   data_a;
    logic [CW-1:0]        cnt_a;

    logic                 gnt_b, vld_b, stray_b;
    logic [31:0]          rdata_b;
    logic [N-1:0]         req_b;
    logic [N-1:0][31:0]   data_b;
    logic [CW-1:0]        cnt_b;

    int n_chk;
    int n_fail;

    addr_dec_resp_mux_outstanding #(
        .NumOut(N), .MaxOutstanding(4), .AggregateGnt(1'b1)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add),
        .data_i(data), .gnt_o(gnt_a), .vld_o(vld_a), .rdata_o(rdata_a),
        .req_o(req_a), .gnt_i(gnt), .vld_i(vld), .data_o(data_a),
        .rdata_i(rdata), .outstanding_o(cnt_a), .stray_vld_o(stray_a)
    );

    addr_dec_resp_mux_outstanding #(
        .NumOut(N), .MaxOutstanding(4), .AggregateGnt(1'b0)
    ) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add),
        .data_i(data), .gnt_o(gnt_b), .vld_o(vld_b), .rdata_o(rdata_b),
        .req_o(req_b), .gnt_i(gnt), .vld_i(vld), .data_o(data_b),
        .rdata_i(rdata), .outstanding_o(cnt_b), .stray_vld_o(stray_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          req;
        int            add;
        logic [N-1:0]  gnt;
        logic [N-1:0]  vld;
        logic [N-1:0]  e_req;
        logic          e_gnt;
        logic          e_vld;
        logic          e_stray;
        int            rlane;
        int            e_cnt;
    } vec_t;

    vec_t vec [22];

    function automatic logic [N-1:0] oh(input int idx);
        logic [N-1:0] r;
        r = '0;
        if (idx >= 0) r[idx] = 1'b1;
        return r;
    endfunction

    function automatic vec_t mkv(input logic rq, input int ad,
                                 input int gl, input int vl,
                                 input int erl, input logic eg,
                                 input logic ev, input logic es,
                                 input int rl, input int ec);
        vec_t v;
        v.req = rq; v.add = ad; v.gnt = oh(gl); v.vld = oh(vl);
        v.e_req = oh(erl); v.e_gnt = eg; v.e_vld = ev;
        v.e_stray = es; v.rlane = rl; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        req = 0; add = '0; data = '0; gnt = '0; vld = '0;
        for (int i = 0; i < N; i++) rdata[i] = 32'hA500_0000 | i;

        // reset with a pending request
        rst_n = 0;
        req = 1; add = 5'd3; gnt = oh(3);
        #12;
        check("rst_cnt", 32'(cnt_a), 32'd0);
        check("rst_vld", 32'(vld_a), 32'd0);
        req = 0; gnt = '0;
        @(negedge clk);
        rst_n = 1;

        // -1 = no lane
        vec[0]  = mkv(1, 3,  3, -1,  3, 1, 0, 0, 0, 1);
        vec[1]  = mkv(0, 0, -1,  3, -1, 0, 1, 0, 3, 0);
        vec[2]  = mkv(1, 5,  5, -1,  5, 1, 0, 0, 0, 1);
        vec[3]  = mkv(1, 5,  5, -1,  5, 1, 0, 0, 0, 2);
        vec[4]  = mkv(1, 5,  5, -1,  5, 1, 0, 0, 0, 3);
        vec[5]  = mkv(1, 5,  5, -1,  5, 1, 0, 0, 0, 4);
        vec[6]  = mkv(1, 5,  5, -1, -1, 0, 0, 0, 0, 4);
        vec[7]  = mkv(1, 5,  5,  5,  5, 1, 1, 0, 5, 4);
        vec[8]  = mkv(0, 5, -1,  5, -1, 0, 1, 0, 5, 3);
        vec[9]  = mkv(0, 5, -1,  5, -1, 0, 1, 0, 5, 2);
        vec[10] = mkv(0, 5, -1,  5, -1, 0, 1, 0, 5, 1);
        vec[11] = mkv(0, 5, -1,  5, -1, 0, 1, 0, 5, 0);
        vec[12] = mkv(1, 2,  2, -1,  2, 1, 0, 0, 0, 1);
        vec[13] = mkv(1, 2,  2, -1,  2, 1, 0, 0, 0, 2);
        vec[14] = mkv(1, 7,  7, -1, -1, 0, 0, 0, 0, 2);
        vec[15] = mkv(1, 7,  7,  2, -1, 0, 1, 0, 2, 1);
        vec[16] = mkv(1, 7,  7,  2,  7, 1, 1, 0, 2, 1);
        vec[17] = mkv(0, 0, -1,  7, -1, 0, 1, 0, 7, 0);
        vec[18] = mkv(0, 0, -1,  7, -1, 0, 0, 1, 0, 0);
        vec[19] = mkv(1, 1,  1, -1,  1, 1, 0, 0, 0, 1);
        vec[20] = mkv(0, 0, -1,  4, -1, 0, 0, 0, 0, 1);
        vec[21] = mkv(0, 0, -1,  1, -1, 0, 1, 0, 1, 0);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            req = vec[i].req; add = LW'(vec[i].add);
            gnt = vec[i].gnt; vld = vec[i].vld;
            data = 32'hDEAD_0000 + 32'(i);
            #1;
            check($sformatf("req_o[%0d]", i), req_a, vec[i].e_req);
            check($sformatf("gnt_o[%0d]", i), 32'(gnt_a), 32'(vec[i].e_gnt));
            check($sformatf("vld_o[%0d]", i), 32'(vld_a), 32'(vec[i].e_vld));
            check($sformatf("stray[%0d]", i), 32'(stray_a),
                  32'(vec[i].e_stray));
            check($sformatf("data_o[%0d]", i), data_a[i % N], data);
            if (vec[i].e_vld)
                check($sformatf("rdata[%0d]", i), rdata_a,
                      32'hA500_0000 | 32'(vec[i].rlane));
            @(posedge clk);
            #1;
            check($sformatf("cnt[%0d]", i), 32'(cnt_a), 32'(vec[i].e_cnt));
        end

        // per-lane grant selection
        @(negedge clk);
        req = 1; add = 5'd1; gnt = 32'h4; vld = '0;
        #1;
        check("sel_gnt_wrong_lane", 32'(gnt_b), 32'd0);
        check("sel_req_o", req_b, 32'h2);
        check("agg_gnt_any_lane", 32'(gnt_a), 32'd1);
        @(posedge clk);
        #1;
        check("sel_cnt_hold", 32'(cnt_b), 32'd0);
        @(negedge clk);
        gnt = 32'h2;
        #1;
        check("sel_gnt_right_lane", 32'(gnt_b), 32'd1);
        @(posedge clk);
        #1;
        check("sel_cnt_inc", 32'(cnt_b), 32'd1);

        // async reset mid-operation
        @(negedge clk);
        req = 0; gnt = '0;
        #2 rst_n = 0;
        #1;
        check("rst1_cnt_a", 32'(cnt_a), 32'd0);
        check("rst1_cnt_b", 32'(cnt_b), 32'd0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = 1; add = 5'd0; gnt = oh(0);
        end
        @(negedge clk);
        req = 0; gnt = '0;
        #1;
        check("pre_rst_cnt", 32'(cnt_a), 32'd3);
        #1 rst_n = 0;
        #1;
        check("mid_rst_cnt", 32'(cnt_a), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        vld = oh(0);
        #1;
        check("late_stray", 32'(stray_a), 32'd1);
        check("late_vld", 32'(vld_a), 32'd0);
        @(posedge clk);
        #1;
        check("late_cnt", 32'(cnt_a), 32'd0);
        @(negedge clk);
        vld = '0;
        #1;
        check("stray_clear", 32'(stray_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
